// File: rtl/img_pkg.sv
// Shared definitions for the grey-image pixel pipeline: default widths, frame FSM states
// and the grey-to-threshold MSB extraction used by every stage that compares against a bin index.
package img_pkg;

  localparam int GREY_W_DEF = 12;
  localparam int THR_W_DEF  = 8;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    REPORT   = 2'd2
  } state_t;

  // Top thr_w bits of a grey_w-bit sample, right-aligned; callers zero-extend into 32 bits.
  function automatic logic [31:0] grey_msb(input logic [31:0] grey, input int grey_w,
                                           input int thr_w);
    return grey >> (grey_w - thr_w);
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Registered frame-valid with start/end-of-frame pulses; combinational pulses, one cycle wide.
// Reset suppresses both pulses and preloads the live level so a frame in progress is not a new edge.
module frame_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_fval,
  output logic o_sof,
  output logic o_eof
);

  logic r_fval_d;

  always_ff @(posedge i_clk) begin
    r_fval_d <= i_fval;
  end

  assign o_sof = i_fval & ~r_fval_d & ~i_rst;
  assign o_eof = ~i_fval & r_fval_d & ~i_rst;

endmodule

// File: rtl/grey_binarize.sv
// Binarizes the grey stream against a per-frame threshold frozen at SOF and counts foreground pixels.
// Latency 2 cycles to oBin; optional BINARIZE_THR_SMOOTH_EN low-pass filters the threshold across frames.
module grey_binarize
  import img_pkg::*;
#(
  parameter int GREY_W = GREY_W_DEF,
  parameter int THR_W  = THR_W_DEF,
  parameter int CNT_W  = 20
) (
  input  logic              iPclk,
  input  logic              iRST,
  input  logic [GREY_W-1:0] iGrey,
  input  logic              iDval,
  input  logic              iFval,
  input  logic [THR_W-1:0]  iThresh,
  output logic              oBin,
  output logic [GREY_W-1:0] oBin_Grey,
  output logic              oDval,
  output logic              oFval,
  output logic [THR_W-1:0]  oThr_Used,
  output logic [CNT_W-1:0]  oFgCount,
  output logic              oCountValid
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_sof;
  logic w_eof;
  logic w_take_sof;
  logic w_accept;
  logic w_fg;

  logic [GREY_W-1:0] r_grey_s1;
  logic              r_dval_s1;
  logic              r_fval_s1;
  logic              r_bin;
  logic              r_dval_s2;
  logic              r_fval_s2;
  logic [THR_W-1:0]  r_thr;
  logic [THR_W-1:0]  w_thr_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_fg_count;
  logic              r_cnt_vld;

  frame_edge_det u_edge (
    .i_clk  (iPclk),
    .i_rst  (iRST),
    .i_fval (iFval),
    .o_sof  (w_sof),
    .o_eof  (w_eof)
  );

  assign w_take_sof = (r_state == WAIT_SOF) && w_sof;
  // The SOF cycle's own pixel belongs to the new frame.
  assign w_accept   = (r_state == ACTIVE) || w_take_sof;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_SOF: if (w_sof) w_state_nxt = ACTIVE;
      ACTIVE:   if (w_eof) w_state_nxt = REPORT;
      REPORT:   w_state_nxt = WAIT_SOF;
      default:  w_state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge iPclk) begin
    if (iRST) begin
      r_state <= WAIT_SOF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef BINARIZE_THR_SMOOTH_EN
  logic             r_first;
  logic [THR_W+1:0] w_thr_sum;

  // (3*old + new + 2) >> 2, with 3*old formed as old + 2*old.
  assign w_thr_sum = {2'b00, r_thr} + {1'b0, r_thr, 1'b0} + {2'b00, iThresh}
                   + (THR_W+2)'(2);
  assign w_thr_nxt = r_first ? iThresh : THR_W'(w_thr_sum >> 2);

  always_ff @(posedge iPclk) begin
    if (iRST) begin
      r_first <= 1'b1;
    end else if (w_take_sof) begin
      r_first <= 1'b0;
    end
  end
`else
  assign w_thr_nxt = iThresh;
`endif

  always_ff @(posedge iPclk) begin
    if (iRST) begin
      r_thr <= '0;
    end else if (w_take_sof) begin
      r_thr <= w_thr_nxt;
    end
  end

  assign w_fg = grey_msb(32'(r_grey_s1), GREY_W, THR_W) > 32'(r_thr);

  always_ff @(posedge iPclk) begin
    if (iRST) begin
      r_grey_s1 <= '0;
      r_dval_s1 <= 1'b0;
      r_fval_s1 <= 1'b0;
      r_bin     <= 1'b0;
      r_dval_s2 <= 1'b0;
      r_fval_s2 <= 1'b0;
    end else begin
      r_grey_s1 <= iGrey;
      r_dval_s1 <= w_accept & iDval & iFval;
      r_fval_s1 <= w_accept & iFval;
      r_bin     <= r_dval_s1 & w_fg;
      r_dval_s2 <= r_dval_s1;
      r_fval_s2 <= r_fval_s1;
    end
  end

  // Counting runs off stage 1, so the last pixel lands before REPORT reads the total.
  always_ff @(posedge iPclk) begin
    if (iRST) begin
      r_cnt <= '0;
    end else if (w_take_sof) begin
      r_cnt <= '0;
    end else if (r_dval_s1 && w_fg && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge iPclk) begin
    if (iRST) begin
      r_fg_count <= '0;
      r_cnt_vld  <= 1'b0;
    end else begin
      r_cnt_vld <= (r_state == REPORT);
      if (r_state == REPORT) begin
        r_fg_count <= r_cnt;
      end
    end
  end

  assign oBin        = r_bin;
  assign oBin_Grey   = {GREY_W{r_bin}};
  assign oDval       = r_dval_s2;
  assign oFval       = r_fval_s2;
  assign oThr_Used   = r_thr;
  assign oFgCount    = r_fg_count;
  assign oCountValid = r_cnt_vld;

endmodule

// File: tb/tb_grey_binarize.sv
// Scoreboard bench for grey_binarize: pixel and frame-count expectations queued at drive time.
// A second instance with a 4-bit counter shares the stimulus to exercise count saturation.
module tb_grey_binarize;

  logic        clk;
  logic        iRST;
  logic [11:0] iGrey;
  logic        iDval;
  logic        iFval;
  logic [7:0]  iThresh;

  logic        oBin;
  logic [11:0] oBin_Grey;
  logic        oDval;
  logic        oFval;
  logic [7:0]  oThr_Used;
  logic [19:0] oFgCount;
  logic        oCountValid;

  logic        bin4;
  logic [11:0] bin_grey4;
  logic        dval4;
  logic        fval4;
  logic [7:0]  thr4;
  logic [3:0]  fgcount4;
  logic        cnt_vld4;

  grey_binarize #(.GREY_W(12), .THR_W(8), .CNT_W(20)) dut (
    .iPclk(clk), .iRST(iRST), .iGrey(iGrey), .iDval(iDval), .iFval(iFval),
    .iThresh(iThresh), .oBin(oBin), .oBin_Grey(oBin_Grey), .oDval(oDval),
    .oFval(oFval), .oThr_Used(oThr_Used), .oFgCount(oFgCount),
    .oCountValid(oCountValid)
  );

  grey_binarize #(.GREY_W(12), .THR_W(8), .CNT_W(4)) dut4 (
    .iPclk(clk), .iRST(iRST), .iGrey(iGrey), .iDval(iDval), .iFval(iFval),
    .iThresh(iThresh), .oBin(bin4), .oBin_Grey(bin_grey4), .oDval(dval4),
    .oFval(fval4), .oThr_Used(thr4), .oFgCount(fgcount4),
    .oCountValid(cnt_vld4)
  );

  typedef struct {
    bit fg;
    int cyc;
  } pix_exp_t;

  pix_exp_t    exp_q[$];
  int          q_cnt[$];
  int          q_cnt4[$];
  logic [11:0] pix_q[$];

  int       n_checks = 0;
  int       n_err    = 0;
  int       n_pulses = 0;
  int       cyc      = 0;
  int       cnt_m    = 0;
  logic [7:0] thr_m  = 8'd0;
  bit       first    = 1'b1;
  int       p0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!iRST) begin
      if (oDval) begin
        chk("fval_with_dval", oFval, 1);
        if (exp_q.size() == 0) begin
          chk("spurious_dval", 1, 0);
        end else begin
          pix_exp_t e;
          e = exp_q.pop_front();
          chk("bin", oBin, e.fg);
          chk("bin_grey", oBin_Grey, {12{e.fg}});
          chk("latency", cyc - e.cyc, 2);
        end
      end else begin
        chk("bin_idle", oBin, 0);
      end
      if (oCountValid) begin
        n_pulses++;
        if (q_cnt.size() == 0) chk("spurious_count", 1, 0);
        else chk("fg_count", oFgCount, q_cnt.pop_front());
      end
      if (cnt_vld4) begin
        if (q_cnt4.size() == 0) chk("spurious_count4", 1, 0);
        else chk("fg_count_sat", fgcount4, q_cnt4.pop_front());
      end
    end
  end

  task automatic add_pix(input logic [11:0] g, input int n);
    repeat (n) pix_q.push_back(g);
  endtask

  task automatic sof_model(input logic [7:0] ith);
`ifdef BINARIZE_THR_SMOOTH_EN
    if (first) thr_m = ith;
    else thr_m = 8'((3 * int'(thr_m) + int'(ith) + 2) / 4);
`else
    thr_m = ith;
`endif
    first = 1'b0;
    cnt_m = 0;
  endtask

  task automatic drive_pix(input logic [11:0] g, input bit live);
    pix_exp_t e;
    iDval = 1'b1;
    iGrey = g;
    if (live) begin
      e.fg  = (g[11:4] > thr_m);
      e.cyc = cyc;
      exp_q.push_back(e);
      if (e.fg) cnt_m++;
    end
  endtask

  // SOF in the first pixel slot; gap = number of iFval-low slots after the frame.
  task automatic run_frame(input logic [7:0] thr, input logic [7:0] mid_thr, input int mid_at,
                           input int gap, input bit live);
    int n;
    n = pix_q.size();
    @(posedge clk); #1;
    iThresh = thr;
    iFval   = 1'b1;
    if (live) sof_model(thr);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (i == 1) chk("thr_used", oThr_Used, thr_m);
      if (i == mid_at) iThresh = mid_thr;
      drive_pix(pix_q[i], live);
    end
    pix_q.delete();
    @(posedge clk); #1;
    iDval = 1'b0;
    iFval = 1'b0;
    iGrey = '0;
    chk("thr_hold", oThr_Used, thr_m);
    if (live) begin
      q_cnt.push_back(cnt_m);
      q_cnt4.push_back(cnt_m > 15 ? 15 : cnt_m);
    end
    repeat (gap - 1) @(posedge clk);
  endtask

  initial begin
    iRST = 1'b1; iGrey = '0; iDval = 1'b0; iFval = 1'b0; iThresh = '0;
    repeat (4) @(posedge clk);
    #1 iRST = 1'b0;
    @(posedge clk); #1;
    chk("rst_bin", oBin, 0);
    chk("rst_dval", oDval, 0);
    chk("rst_fval", oFval, 0);
    chk("rst_thr", oThr_Used, 0);
    chk("rst_count", oFgCount, 0);
    chk("rst_count_vld", oCountValid, 0);

    // Basic frame: 0x64 is not above 100, 0x65 is.
    add_pix(12'h640, 1); add_pix(12'h650, 1); add_pix(12'h63F, 1); add_pix(12'hFFF, 1);
    run_frame(8'd100, 8'd100, 99, 3, 1'b1);

    // Threshold drops to 10 mid-frame; this frame keeps its SOF threshold.
    add_pix(12'h640, 1); add_pix(12'h650, 1); add_pix(12'h63F, 1); add_pix(12'hFFF, 1);
    run_frame(8'd100, 8'd10, 2, 3, 1'b1);

    // Next frame uses the new threshold; 21 foreground pixels saturate the 4-bit counter.
    add_pix(12'h0A0, 1); add_pix(12'h0B0, 1); add_pix(12'h000, 1); add_pix(12'hFFF, 20);
    run_frame(8'd10, 8'd10, 99, 3, 1'b1);

    repeat (4) @(posedge clk);
    #1 p0 = n_pulses;
    iDval = 1'b1; iGrey = 12'hFFF;
    repeat (50) @(posedge clk);
    #1 iDval = 1'b0; iGrey = '0;
    repeat (6) @(posedge clk);
    chk("gated_no_count", n_pulses, p0);

    // Only one low cycle before the second frame: it falls in REPORT and is skipped.
    p0 = n_pulses;
    add_pix(12'hFFF, 4);
    run_frame(8'd40, 8'd40, 99, 1, 1'b1);
    add_pix(12'hFFF, 6);
    run_frame(8'd200, 8'd200, 99, 3, 1'b0);
    add_pix(12'hFFF, 3); add_pix(12'h100, 1);
    run_frame(8'd60, 8'd60, 99, 3, 1'b1);
    repeat (4) @(posedge clk);
    chk("skip_pulses", n_pulses - p0, 2);

    // Reset in the middle of a frame after 30 foreground pixels.
    @(posedge clk); #1;
    iThresh = 8'd50; iFval = 1'b1;
    sof_model(8'd50);
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      drive_pix(12'hFFF, 1'b1);
    end
    @(posedge clk); #1 iDval = 1'b0;
    repeat (3) @(posedge clk);
    #1 iRST = 1'b1;
    thr_m = 8'd0; first = 1'b1;
    repeat (2) @(posedge clk);
    #1 iRST = 1'b0;
    p0 = n_pulses;
    chk("midrst_thr", oThr_Used, 0);
    chk("midrst_count", oFgCount, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive_pix(12'hFFF, 1'b0);
    end
    @(posedge clk); #1;
    iDval = 1'b0; iFval = 1'b0;
    repeat (5) @(posedge clk);
    chk("midrst_no_report", n_pulses, p0);

    // Fresh frame reports only its own count; then 100 -> 200 threshold step.
    add_pix(12'hFFF, 5); add_pix(12'h100, 3);
    run_frame(8'd100, 8'd100, 99, 3, 1'b1);
    add_pix(12'hD00, 4); add_pix(12'h500, 1);
    run_frame(8'd200, 8'd200, 99, 3, 1'b1);

    repeat (8) @(posedge clk);
    chk("pix_queue_empty", exp_q.size(), 0);
    chk("count_queue_empty", q_cnt.size(), 0);
    chk("count4_queue_empty", q_cnt4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/grey_binarize.md
Name: grey_binarize

Overview:
- Pixel-stream stage directly downstream of the histogram block.
- Applies that block's per-frame threshold output (8-bit, the bin index where the cumulative count crosses the limit) to the live grey stream.
- Produces a binary foreground mask for display and counts foreground pixels per frame.
- The threshold is frozen at frame start, so one frame is never split across two thresholds.

Parameters:
- GREY_W, 12, width of incoming grey sample.
- THR_W, 8, threshold width; compares against grey MSBs [GREY_W-1 : GREY_W-THR_W].
- CNT_W, 20, foreground counter width; covers 640x480 with margin.

Ports:
- iPclk  in  1  pixel clock; the only clock.
- iRST  in  1  synchronous, active-high reset.
- iGrey  in  GREY_W  grey sample.
- iDval  in  1  sample valid.
- iFval  in  1  frame valid; high during the active frame.
- iThresh  in  THR_W  threshold from the histogram stage (threshOut).
- oBin  out  1  foreground flag: 1 when grey MSBs > threshold.
- oBin_Grey  out  GREY_W  oBin replicated to all bits, for the VGA path.
- oDval  out  1  iDval delayed to align with oBin.
- oFval  out  1  iFval delayed to align with oBin.
- oThr_Used  out  THR_W  threshold applied in the current or most recent frame.
- oFgCount  out  CNT_W  foreground count of the last completed frame.
- oCountValid  out  1  one-cycle pulse when oFgCount updates.

Behaviour:
- Reset: all outputs 0, state = WAIT_SOF, internal threshold register 0, counter 0. Reset overrides every other event in the same cycle.
- Edge detect: one-cycle-delayed copy fval_d of iFval.
  - SOF = iFval & ~fval_d.
  - EOF = ~iFval & fval_d.
- States:
  - WAIT_SOF: discard all pixels; oDval forced 0. On SOF: latch iThresh into thr_reg, clear counter, go to ACTIVE. The SOF cycle's own pixel is processed if iDval=1.
  - ACTIVE: each cycle with iDval & iFval, compute fg = (iGrey[GREY_W-1 -: THR_W] > thr_reg), strictly greater. When fg=1, counter += 1, saturating at all-ones. On EOF go to REPORT.
  - REPORT: one cycle. oFgCount <= counter; oCountValid = 1; go to WAIT_SOF.
    - If iFval is already high again in this cycle, that SOF is missed and the frame skipped. Verification must check the skip.
- Pipeline: 2 cycles from inputs to oBin/oBin_Grey/oDval/oFval.
  - Stage 1 registers grey, Dval, Fval.
  - Stage 2 registers the compare result.
  - When stage-1 Dval=0, oBin and oBin_Grey = 0.
- Gating:
  - iDval while iFval=0 is ignored: oDval stays 0 and nothing is counted.
  - iThresh changes mid-frame have no effect until the next SOF.
- Reset mid-frame: return to WAIT_SOF. Outputs stay quiet until a fresh rising edge of iFval; no partial-frame count is ever reported.
- oThr_Used = thr_reg; it updates one cycle after SOF.
- Back-to-back frames: require at least 2 cycles of iFval low between frames.

Optional Feature:
- Macro BINARIZE_THR_SMOOTH_EN.
- Defined: at SOF, thr_reg <= (3*thr_reg + iThresh + 2) >> 2, computed in THR_W+2 bits and rounded. The first frame after reset loads iThresh directly (first-frame flag). This damps frame-to-frame threshold flicker.
- Undefined: thr_reg <= iThresh at SOF. No extra logic.

Decomposition:
- Shared package img_pkg holds:
  - GREY_W and THR_W defaults;
  - the state enum {WAIT_SOF, ACTIVE, REPORT};
  - the function grey_msb(grey) that extracts the THR_W MSBs.
- One natural sub-module: frame_edge_det (registered Fval, SOF/EOF pulses). It is reusable by the histogram stage.

Test Plan:
- iThresh=100, SOF, then 4 valid pixels with iGrey = 0x640, 0x650, 0x63F, 0xFFF, then EOF:
  - oBin = 0,1,0,1, each two cycles after its input.
  - oCountValid pulses once with oFgCount=2.
- Change iThresh from 100 to 10 in mid-frame: oThr_Used stays 100 and the count is unchanged; the next frame uses 10.
- iDval=1 with iFval=0 for 50 cycles: oDval=0, no count, no oCountValid.
- Assert iRST mid-frame after 30 foreground pixels, release, let that frame finish: no oCountValid. The next full frame reports only its own count.
- CNT_W=4, frame with 20 foreground pixels: oFgCount=15 (saturated).
- With BINARIZE_THR_SMOOTH_EN, iThresh 100 then 200 on consecutive frames: oThr_Used = 100, then 125 ((300+200+2)>>2).
